// File: rtl/scan_test_seq.sv
// Scan sequencer for ATPG mode: walks load/capture/unload cycles over the scan chains,
// driving scan_en plus gated shift/capture clock enables from a handshaken bit source.
module scan_test_seq #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 8,
    parameter int PAT_W     = 16,
    parameter int SETTLE    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_mode,
    input  logic             start,
    input  logic [PAT_W-1:0] num_pat,
    input  logic [1:0]       cap_cycles,
    input  logic             pat_vld,
    output logic             pat_rdy,
    output logic             scan_en,
    output logic             shift_ce,
    output logic             cap_ce,
    output logic             unload_vld,
    output logic [PAT_W-1:0] pat_idx,
    output logic [CNT_W-1:0] shift_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_SE_FALL,
        S_CAPTURE,
        S_SE_RISE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] num_pat_q, num_pat_d;
    logic [PAT_W-1:0] pat_idx_q, pat_idx_d;
    logic [1:0]       cap_last_q, cap_last_d;
    logic [CNT_W-1:0] shift_idx_q, shift_idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             accept;

    assign accept = (state_q == S_SHIFT) && pat_vld;

    always_comb begin
        state_d     = state_q;
        num_pat_d   = num_pat_q;
        cap_last_d  = cap_last_q;
        pat_idx_d   = pat_idx_q;
        shift_idx_d = shift_idx_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && test_mode) begin
                    num_pat_d   = num_pat;
                    // A capture count of 0 still fires one pulse.
                    cap_last_d  = (cap_cycles == 2'd0) ? 2'd0 : cap_cycles - 2'd1;
                    pat_idx_d   = '0;
                    shift_idx_d = '0;
                    cnt_d       = '0;
                    state_d     = (num_pat != '0) ? S_PRE : S_DONE;
                end
            end
            S_PRE: state_d = S_SHIFT;
            S_SHIFT: begin
                if (accept) begin
                    if (shift_idx_q == SHIFT_LAST) begin
                        shift_idx_d = '0;
                        cnt_d       = '0;
                        state_d     = (pat_idx_q < num_pat_q) ? S_SE_FALL : S_DONE;
                    end else begin
                        shift_idx_d = shift_idx_q + CNT_W'(1);
                    end
                end
            end
            S_SE_FALL: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CAPTURE: begin
                if (cnt_q == {2'b00, cap_last_q}) begin
                    cnt_d   = '0;
                    state_d = S_SE_RISE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SE_RISE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d     = '0;
                    pat_idx_d = pat_idx_q + PAT_W'(1);
                    state_d   = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Leaving test mode wins over any transition; an in-flight shift accept still lands.
        if (!test_mode && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_DONE;
            pat_idx_d = pat_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_idx_q   <= '0;
            shift_idx_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pat_idx_q   <= pat_idx_d;
            shift_idx_q <= shift_idx_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        num_pat_q  <= num_pat_d;
        cap_last_q <= cap_last_d;
    end

    assign pat_rdy    = (state_q == S_SHIFT);
    assign scan_en    = (state_q == S_PRE) || (state_q == S_SHIFT) || (state_q == S_SE_RISE);
    assign cap_ce     = (state_q == S_CAPTURE);
    assign shift_ce   = accept;
    assign unload_vld = accept && (pat_idx_q != '0);
    assign pat_idx    = pat_idx_q;
    assign shift_idx  = shift_idx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
